// File: rtl/sponge_pkg.sv
// Shared definitions for the sponge duplex controller: FSM states and the
// domain-separator encoding presented to the external permutation.
package sponge_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ABS_WAIT = 3'd1,
      ABS_PERM = 3'd2,
      SQZ_EMIT = 3'd3,
      SQZ_PERM = 3'd4,
      DONE     = 3'd5
   } sponge_state_e;

   localparam logic [3:0] DS_NONE = 4'b0000;

   // Domain separator: {domain, finalize, padded}
   function automatic logic [3:0] ds_encode(input logic [1:0] dom,
                                            input logic       fin,
                                            input logic       pad);
      return {dom, fin, pad};
   endfunction

endpackage

// File: rtl/sponge_pad.sv
// Byte mask and 0x01 pad of the final absorb block; non-final blocks pass
// through untouched.
module sponge_pad #(
   parameter int RATE_W = 128,
   parameter int NBY_W  = $clog2(RATE_W/8) + 1
) (
   input  logic [RATE_W-1:0] data,
   input  logic [NBY_W-1:0]  nbytes,
   input  logic              last,
   output logic [RATE_W-1:0] block,
   output logic              padded
);

   localparam int NB = RATE_W / 8;

   // Keep bytes below nbytes, drop 0x01 at index nbytes, zero the rest
   always_comb begin
      block  = '0;
      padded = last && (32'(nbytes) < NB);
      for (int b = 0; b < NB; b++) begin
         if (!last || (b < 32'(nbytes)))
            block[b*8 +: 8] = data[b*8 +: 8];
         else if (b == 32'(nbytes))
            block[b*8 +: 8] = 8'h01;
      end
   end

endmodule

// File: rtl/sponge_duplex_ctrl.sv
// Sponge duplex sequencer: absorbs rate blocks into the state, squeezes
// output words, and hands the state to an external permutation between steps.
//
//   state    | meaning
//   IDLE     | waiting for start
//   ABS_WAIT | in_ready high, waiting for an absorb block
//   ABS_PERM | permutation running after an absorbed block
//   SQZ_EMIT | out_valid high, presenting a squeeze word
//   SQZ_PERM | permutation running between squeeze words
//   DONE     | done high, state_out valid until the next start
module sponge_duplex_ctrl
   import sponge_pkg::*;
#(
   parameter int STATE_W = 320,
   parameter int RATE_W  = 128,
   parameter int SQZ_W   = 192,
   parameter int LEN_W   = 20,
   parameter int RND_W   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      mode,
   input  logic [STATE_W-1:0]        state_in,
   input  logic [1:0]                domain,
   input  logic                      finalize,
   input  logic [RND_W-1:0]          rounds,
   input  logic [LEN_W-1:0]          sqz_bits,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [RATE_W-1:0]         in_data,
   input  logic [$clog2(RATE_W/8):0] in_nbytes,
   input  logic                      in_last,
   output logic                      perm_start,
   output logic [STATE_W-1:0]        perm_state,
   output logic [3:0]                perm_ds,
   output logic [RND_W-1:0]          perm_rounds,
   input  logic                      perm_done,
   input  logic [STATE_W-1:0]        perm_result,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SQZ_W-1:0]          out_data,
   output logic [$clog2(SQZ_W):0]    out_nbits,
   output logic                      out_last,
   output logic [STATE_W-1:0]        state_out,
   output logic                      done
);

   localparam int NBI_W = $clog2(SQZ_W) + 1;

   sponge_state_e      st, st_nxt;
   logic [STATE_W-1:0] state_q;
   logic [1:0]         domain_q;
   logic               fin_q;
   logic [RND_W-1:0]   rounds_q;
   logic [LEN_W-1:0]   rem_q;
   logic               last_q;
   logic               perm_start_q;
   logic [3:0]         ds_q;

   logic [RATE_W-1:0]  pad_block;
   logic               pad_padded;
   logic [NBI_W-1:0]   nbits;
   logic               sqz_last;
   logic [SQZ_W-1:0]   sqz_mask;

   sponge_pad #(.RATE_W(RATE_W)) u_pad (
      .data   (in_data),
      .nbytes (in_nbytes),
      .last   (in_last),
      .block  (pad_block),
      .padded (pad_padded)
   );

   // Squeeze word length and valid-bit mask from the remaining bit count
   always_comb begin
      sqz_last = (32'(rem_q) <= SQZ_W);
      nbits    = sqz_last ? NBI_W'(rem_q) : NBI_W'(SQZ_W);
      sqz_mask = '0;
      for (int i = 0; i < SQZ_W; i++)
         sqz_mask[i] = (i < 32'(nbits));
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= IDLE;
      else        st <= st_nxt;
   end

   // FSM next-state logic
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:     if (start)
                      st_nxt = !mode ? ABS_WAIT : ((sqz_bits == '0) ? DONE : SQZ_EMIT);
         ABS_WAIT: if (in_valid)  st_nxt = ABS_PERM;
         ABS_PERM: if (perm_done) st_nxt = last_q ? DONE : ABS_WAIT;
         SQZ_EMIT: if (out_ready) st_nxt = sqz_last ? DONE : SQZ_PERM;
         SQZ_PERM: if (perm_done) st_nxt = SQZ_EMIT;
         DONE:     if (start)     st_nxt = IDLE;
         default:                 st_nxt = IDLE;
      endcase
   end

   // Datapath: state register, latched command fields, permutation request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= '0;
         domain_q     <= '0;
         fin_q        <= 1'b0;
         rounds_q     <= '0;
         rem_q        <= '0;
         last_q       <= 1'b0;
         perm_start_q <= 1'b0;
         ds_q         <= DS_NONE;
      end else begin
         perm_start_q <= 1'b0;
         case (st)
            IDLE: if (start) begin
               state_q  <= state_in;
               domain_q <= domain;
               fin_q    <= finalize;
               rounds_q <= rounds;
               rem_q    <= sqz_bits;
               last_q   <= 1'b0;
               ds_q     <= DS_NONE;
            end
            ABS_WAIT: if (in_valid) begin
               state_q[RATE_W-1:0] <= state_q[RATE_W-1:0] ^ pad_block;
               last_q       <= in_last;
               perm_start_q <= 1'b1;
               ds_q         <= in_last ? ds_encode(domain_q, fin_q, pad_padded) : DS_NONE;
            end
            ABS_PERM, SQZ_PERM: if (perm_done) state_q <= perm_result;
            SQZ_EMIT: if (out_ready) begin
               rem_q <= rem_q - LEN_W'(nbits);
               if (!sqz_last) begin
                  perm_start_q <= 1'b1;
                  ds_q         <= ds_encode(domain_q, fin_q, 1'b0);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; all zero while held in reset
   always_comb begin
      in_ready    = (st == ABS_WAIT);
      out_valid   = (st == SQZ_EMIT);
      done        = (st == DONE);
      out_last    = out_valid && sqz_last;
      out_nbits   = out_valid ? nbits : '0;
      out_data    = out_valid ? (state_q[SQZ_W-1:0] & sqz_mask) : '0;
      state_out   = done ? state_q : '0;
      perm_start  = perm_start_q;
      perm_state  = state_q;
      perm_ds     = ds_q;
      perm_rounds = rounds_q;
   end

endmodule

// File: tb/tb_sponge_duplex_ctrl.sv
// Bench for sponge_duplex_ctrl: identity-XOR-1 permutation responder,
// queues of expected domain separators and squeeze words.
module tb_sponge_duplex_ctrl;

   logic         clk, reset, start, mode, finalize;
   logic [319:0] state_in;
   logic [1:0]   domain;
   logic [3:0]   rounds;
   logic [19:0]  sqz_bits;
   logic         in_valid, in_ready, in_last;
   logic [127:0] in_data;
   logic [4:0]   in_nbytes;
   logic         perm_start, perm_done;
   logic [319:0] perm_state, perm_result;
   logic [3:0]   perm_ds, perm_rounds;
   logic         out_valid, out_ready, out_last;
   logic [191:0] out_data;
   logic [8:0]   out_nbits;
   logic [319:0] state_out;
   logic         done;

   typedef struct packed {
      logic [191:0] data;
      logic [8:0]   nb;
      logic         last;
   } word_t;

   logic [3:0]   ds_exp[$];
   word_t        wq[$];
   int           n_chk = 0, n_fail = 0, n_pstart = 0;
   logic [3:0]   exp_rounds;
   logic [1:0]   dom_m;
   logic         fin_m;
   logic [319:0] mst;
   logic         perm_en, inject_late;

   sponge_duplex_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .state_in(state_in),
      .domain(domain), .finalize(finalize), .rounds(rounds), .sqz_bits(sqz_bits),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_nbytes(in_nbytes), .in_last(in_last), .perm_start(perm_start),
      .perm_state(perm_state), .perm_ds(perm_ds), .perm_rounds(perm_rounds),
      .perm_done(perm_done), .perm_result(perm_result), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_nbits(out_nbits),
      .out_last(out_last), .state_out(state_out), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [319:0] rnd320();
      logic [319:0] r;
      for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] tb_pad(input logic [127:0] d, input int nb, input logic last);
      logic [127:0] r;
      if (!last || nb >= 16) return d;
      r = d & ((128'd1 << (nb*8)) - 128'd1);
      r = r | (128'h01 << (nb*8));
      return r;
   endfunction

   // Permutation model: result = state ^ 1, two cycles after the request
   initial begin : perm_model
      int cnt;
      logic [319:0] cap;
      cnt = 0;
      cap = '0;
      perm_done = 1'b0;
      perm_result = '0;
      forever begin
         @(negedge clk);
         perm_done = 1'b0;
         if (inject_late) begin
            perm_done   = 1'b1;
            perm_result = {10{32'hdeadbeef}};
            inject_late = 1'b0;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               perm_done   = 1'b1;
               perm_result = cap ^ 320'd1;
            end
         end
         if (perm_start === 1'b1) begin
            n_pstart++;
            if (ds_exp.size() == 0) chk("perm_unexpected", 320'(1'b1), 320'(1'b0));
            else                    chk("perm_ds", 320'(perm_ds), 320'(ds_exp.pop_front()));
            chk("perm_rounds", 320'(perm_rounds), 320'(exp_rounds));
            if (perm_en) begin
               cap = perm_state;
               cnt = 2;
            end
         end
      end
   end

   task automatic do_start(input logic m, input logic [319:0] s, input logic [1:0] d,
                           input logic f, input logic [3:0] r, input logic [19:0] bits);
      mode = m; state_in = s; domain = d; finalize = f; rounds = r; sqz_bits = bits;
      dom_m = d; fin_m = f; exp_rounds = r; mst = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic leave_done();
      start = 1'b1; mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("done_clear", 320'(done), 320'(1'b0));
   endtask

   task automatic absorb(input logic [127:0] d, input int nb, input logic last);
      logic [127:0] pb;
      logic pad;
      int k;
      pb  = tb_pad(d, nb, last);
      pad = last && (nb < 16);
      ds_exp.push_back(last ? {dom_m, fin_m, pad} : 4'b0000);
      mst[127:0] = mst[127:0] ^ pb;
      mst = mst ^ 320'd1;
      in_valid = 1'b1; in_data = d; in_nbytes = 5'(nb); in_last = last;
      for (k = 0; k < 50 && !in_ready; k++) @(negedge clk);
      if (!in_ready) chk("in_ready_timeout", 320'(in_ready), 320'(1'b1));
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 100 && !done; k++) @(negedge clk);
      chk("done_timeout", 320'(done), 320'(1'b1));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [319:0] s;
      logic [191:0] held, mk;
      word_t w;
      int rem, nb, nw, ps0;
      logic got_last;

      reset = 1'b0; start = 1'b0; mode = 1'b0; state_in = '0; domain = '0;
      finalize = 1'b0; rounds = '0; sqz_bits = '0; in_valid = 1'b0; in_data = '0;
      in_nbytes = '0; in_last = 1'b0; out_ready = 1'b0;
      perm_en = 1'b1; inject_late = 1'b0; exp_rounds = '0; dom_m = '0; fin_m = 1'b0; mst = '0;

      // Reset state, with start asserted while held in reset
      repeat (3) @(negedge clk);
      start = 1'b1; mode = 1'b1; sqz_bits = 20'd5;
      @(negedge clk);
      start = 1'b0;
      chk("rst_done",       320'(done),       320'(1'b0));
      chk("rst_in_ready",   320'(in_ready),   320'(1'b0));
      chk("rst_out_valid",  320'(out_valid),  320'(1'b0));
      chk("rst_perm_start", 320'(perm_start), 320'(1'b0));
      chk("rst_state_out",  state_out,        320'(0));
      chk("rst_perm_state", perm_state,       320'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("rel_perm_start", 320'(perm_start), 320'(1'b0));
      chk("rel_idle", 320'({in_ready, out_valid, done}), 320'(0));

      // Two full blocks, domain=2, finalize=1
      ps0 = n_pstart;
      do_start(1'b0, rnd320(), 2'd2, 1'b1, 4'd6, 20'd0);
      chk("a_in_ready", 320'(in_ready), 320'(1'b1));
      start = 1'b1; mode = 1'b1; sqz_bits = 20'd64;
      @(negedge clk);
      start = 1'b0;
      chk("a_start_ignored", 320'({in_ready, out_valid}), 320'(2'b10));
      absorb(rnd320()[127:0], 16, 1'b0);
      absorb(rnd320()[127:0], 16, 1'b1);
      wait_done();
      chk("a_state_out", state_out, mst);
      chk("a_pstarts", 320'(n_pstart - ps0), 320'(2));
      chk("a_last_ds", 320'(perm_ds), 320'(4'b1010));

      // One partial block of 5 bytes
      leave_done();
      s = rnd320();
      do_start(1'b0, s, 2'd1, 1'b0, 4'd3, 20'd0);
      absorb(rnd320()[127:0], 5, 1'b1);
      wait_done();
      chk("b_state_out", state_out, mst);
      chk("b_bytes6_15", 320'(state_out[127:48]), 320'(s[127:48]));
      chk("b_byte5", 320'(state_out[47:40]), 320'(s[47:40] ^ 8'h01));
      chk("b_ds_padded", 320'(perm_ds[0]), 320'(1'b1));

      // Squeeze 400 bits with a 5-cycle stall on the first word
      leave_done();
      s = rnd320();
      ps0 = n_pstart;
      rem = 400;
      mst = s;
      do begin
         nb = (rem > 192) ? 192 : rem;
         mk = {192{1'b1}} >> (192 - nb);
         w.data = mst[191:0] & mk;
         w.nb   = 9'(nb);
         w.last = (rem <= 192);
         wq.push_back(w);
         rem -= nb;
         if (!w.last) begin
            mst = mst ^ 320'd1;
            ds_exp.push_back(4'b1110);
         end
      end while (!w.last);
      out_ready = 1'b0;
      do_start(1'b1, s, 2'd3, 1'b1, 4'd12, 20'd400);
      mst = s;
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      chk("c_first_valid", 320'(out_valid), 320'(1'b1));
      held = out_data;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("c_stall_valid", 320'(out_valid), 320'(1'b1));
         chk("c_stall_data",  320'(out_data),  320'(held));
      end
      chk("c_stall_no_perm", 320'(n_pstart - ps0), 320'(0));
      out_ready = 1'b1;
      nw = 0;
      got_last = 1'b0;
      for (int k = 0; k < 100 && !got_last; k++) begin
         if (out_valid) begin
            if (wq.size() == 0) begin
               chk("c_extra_word", 320'(1'b1), 320'(1'b0));
               got_last = 1'b1;
            end else begin
               w = wq.pop_front();
               chk("c_out_data",  320'(out_data),  320'(w.data));
               chk("c_out_nbits", 320'(out_nbits), 320'(w.nb));
               chk("c_out_last",  320'(out_last),  320'(w.last));
               nw++;
               got_last = out_last;
            end
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      chk("c_words", 320'(nw), 320'(3));
      chk("c_pstarts", 320'(n_pstart - ps0), 320'(2));
      wait_done();
      chk("c_state_out", state_out, mst);

      // Zero-length squeeze
      leave_done();
      ps0 = n_pstart;
      do_start(1'b1, rnd320(), 2'd0, 1'b0, 4'd1, 20'd0);
      chk("z_done", 320'(done), 320'(1'b1));
      chk("z_out_valid", 320'(out_valid), 320'(1'b0));
      chk("z_no_perm", 320'(n_pstart - ps0), 320'(0));

      // Reset in the middle of ABS_PERM, then a stray perm_done
      leave_done();
      perm_en = 1'b0;
      ps0 = n_pstart;
      do_start(1'b0, rnd320(), 2'd1, 1'b1, 4'd5, 20'd0);
      absorb(rnd320()[127:0], 16, 1'b1);
      chk("e_in_perm", 320'(perm_start), 320'(1'b1));
      reset = 1'b0;
      #1;
      chk("e_rst_perm_start", 320'(perm_start), 320'(1'b0));
      chk("e_rst_perm_state", perm_state, 320'(0));
      chk("e_rst_perm_ds", 320'(perm_ds), 320'(0));
      chk("e_rst_flags", 320'({in_ready, out_valid, done}), 320'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("e_rel_perm_start", 320'(perm_start), 320'(1'b0));
      inject_late = 1'b1;
      repeat (3) @(negedge clk);
      chk("e_late_flags", 320'({in_ready, out_valid, done}), 320'(0));
      chk("e_late_state", perm_state, 320'(0));
      chk("e_late_pstarts", 320'(n_pstart - ps0), 320'(1));
      perm_en = 1'b1;

      chk("ds_queue_empty", 320'(ds_exp.size()), 320'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sponge_duplex_ctrl.md
SPONGE_DUPLEX_CTRL -- requirements
Module: sponge_duplex_ctrl

Interface
REQ-001 Parameter STATE_W, default 320, SHALL set the sponge state width in bits.
REQ-002 Parameter RATE_W, default 128, SHALL set the absorb rate (bits per input block, ≤ STATE_W).
REQ-003 Parameter SQZ_W, default 192, SHALL set the squeeze rate (bits per output word, ≤ STATE_W).
REQ-004 Parameter LEN_W, default 20, SHALL set the width of the squeeze bit counter.
REQ-005 Parameter RND_W, default 4, SHALL set the width of the rounds field.
REQ-006 Ports SHALL be:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle command pulse, accepted only in IDLE.
- mode  in  1  operation select: 0 absorb, 1 squeeze; sampled with start.
- state_in  in  STATE_W  initial state; sampled with start.
- domain  in  2  domain field; sampled with start.
- finalize  in  1  finalize flag; sampled with start.
- rounds  in  RND_W  round count; sampled with start.
- sqz_bits  in  LEN_W  number of bits to squeeze; sampled with start.
- in_valid, in_ready  in/out  1  absorb block handshake.
- in_data  in  RATE_W  absorb block data.
- in_nbytes  in  clog2(RATE_W/8)+1  valid bytes in the block; honoured only on the last block.
- in_last  in  1  marks the final absorb block.
- perm_start  out  1  one-cycle permutation request.
- perm_state  out  STATE_W  state presented to the permutation.
- perm_ds  out  4  domain separator presented to the permutation.
- perm_rounds  out  RND_W  round count presented to the permutation.
- perm_done  in  1  permutation complete; perm_result is valid in the same cycle.
- perm_result  in  STATE_W  permuted state.
- out_valid, out_ready  out/in  1  squeeze output handshake.
- out_data  out  SQZ_W  squeeze output word.
- out_nbits  out  clog2(SQZ_W)+1  valid bits in out_data.
- out_last  out  1  marks the final squeeze word.
- state_out  out  STATE_W  final state.
- done  out  1  completion flag.

Function
REQ-007 The FSM SHALL have exactly these states: IDLE, ABS_WAIT, ABS_PERM, SQZ_EMIT, SQZ_PERM, DONE.
REQ-008 IDLE SHALL move, on start, to ABS_WAIT (mode=0) or SQZ_EMIT (mode=1), loading the state register from state_in and latching domain, finalize, rounds and sqz_bits.
REQ-009 In ABS_WAIT, in_ready SHALL be 1; a handshake SHALL XOR the block into state[RATE_W-1:0] and move to ABS_PERM with perm_start=1 for exactly one cycle.
REQ-010 The last block SHALL be masked to in_nbytes; if in_nbytes < RATE_W/8, byte 0x01 SHALL be written at byte index in_nbytes before the XOR and padded=1; otherwise padded=0.
REQ-011 perm_ds SHALL be 0 for non-last blocks and {domain, finalize, padded} for the last block.
REQ-012 In ABS_PERM, on perm_done the state SHALL load perm_result, and the FSM SHALL move to ABS_WAIT (not last) or DONE (last).
REQ-013 In SQZ_EMIT, out_valid SHALL be 1 with out_nbits = min(remaining, SQZ_W); out_data SHALL be state[SQZ_W-1:0] with bits ≥ out_nbits forced to 0; out_last = (remaining ≤ SQZ_W).
REQ-014 On an out handshake, remaining SHALL decrease by out_nbits; the FSM SHALL move to DONE if out_last, else to SQZ_PERM with a perm_start pulse and perm_ds = {domain, finalize, 1'b0}.
REQ-015 Squeeze with sqz_bits=0 SHALL go directly to DONE without asserting out_valid.
REQ-016 In DONE, done SHALL be 1 and state_out SHALL equal the state register; the FSM SHALL return to IDLE on the next start (done clears).
REQ-017 start outside IDLE SHALL be ignored; in_valid outside ABS_WAIT SHALL NOT be consumed.
REQ-018 perm_done arriving outside ABS_PERM/SQZ_PERM SHALL be ignored.
REQ-019 out_data/out_valid SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-020 While reset=0, the FSM SHALL be in IDLE and all registers and all outputs SHALL be 0, including mid-operation; no perm_start SHALL occur in the first cycle after release.

Structure
REQ-021 The FSM state enum and the DS encoding SHALL reside in package sponge_pkg.
REQ-022 Sub-module sponge_pad (combinational byte mask/pad of the last block) SHALL be instantiated once; the permutation SHALL remain external.

Verification
REQ-023 Absorb 2 full blocks, perm model = identity XOR 1, domain=2, finalize=1 -> perm_ds sequence 0 then 4'b1010; done=1.
REQ-024 Absorb 1 block with in_nbytes=5 -> state byte 5 XOR 0x01, bytes 6..15 unchanged, perm_ds[0]=1.
REQ-025 Squeeze sqz_bits=400, SQZ_W=192 -> three words with out_nbits 192, 192, 16; two perm_start pulses; out_last on the third word.
REQ-026 Squeeze with out_ready held 0 for 5 cycles -> out_data stable, no state change.
REQ-027 reset pulsed low during ABS_PERM -> IDLE, outputs 0, and a late perm_done is ignored.
REQ-028 Squeeze sqz_bits=0 -> done on the cycle after start; out_valid never asserted.
